// File: rtl/trojan_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trojan_chk_pkg
// Brief   : Shared FSM states and MISR constants for the trojan response checker.
// Revision: 1.0 - initial release
// ============================================================================
package trojan_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    localparam logic [15:0] SIG_POLY = 16'h1021;

endpackage
`default_nettype wire

// File: rtl/trojan_misr.sv
`default_nettype none
// ============================================================================
// Module  : trojan_misr
// Brief   : Multiple-input signature register folding DUT responses into a signature.
// Revision: 1.0 - initial release
// ============================================================================
module trojan_misr
    import trojan_chk_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int N_OUT = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [N_OUT-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    always_comb begin
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? SIG_W'(SIG_POLY) : '0)
                   ^ SIG_W'(data);
    end

    // clr has priority so a start always reseeds, even if a sample coincides
    always_ff @(posedge CK) begin
        if (!reset) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= SIG_W'(SIG_SEED);
        end else if (en) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/trojan_response_checker.sv
`default_nettype none
// ============================================================================
// Module  : trojan_response_checker
// Brief   : Compares (vector, response) pairs to a golden table, tracks coverage,
//           mismatches, first failure and a MISR signature.
// Revision: 1.0 - initial release
// ============================================================================
module trojan_response_checker
    import trojan_chk_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int SIG_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             gold_we,
    input  logic [N_IN-1:0]  gold_addr,
    input  logic [N_OUT-1:0] gold_data,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic [N_OUT-1:0] in_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_vld,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic [N_OUT-1:0] first_fail_resp,
    output logic [SIG_W-1:0] signature
);

    localparam int c_DEPTH = 2 ** N_IN;

    state_e             r_state;
    state_e             w_state_next;
    logic [N_OUT-1:0]   r_gold [c_DEPTH];
    logic [c_DEPTH-1:0] r_cov;
    logic [c_DEPTH-1:0] w_cov_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ff_vld;
    logic [N_IN-1:0]    r_ff_vec;
    logic [N_OUT-1:0]   r_ff_resp;
    logic               w_xfer;
    logic               w_start;
    logic               w_mis;

    always_comb begin
        w_xfer     = in_valid && (r_state == RUN);
        w_start    = start && (r_state != RUN);
        w_mis      = (in_resp != r_gold[in_vec]);
        w_cov_next = r_cov | (c_DEPTH'(1) << in_vec);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_xfer && (&w_cov_next)) w_state_next = DONE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cov     <= '0;
            r_cnt     <= '0;
            r_ff_vld  <= 1'b0;
            r_ff_vec  <= '0;
            r_ff_resp <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_cov     <= '0;
                r_cnt     <= '0;
                r_ff_vld  <= 1'b0;
                r_ff_vec  <= '0;
                r_ff_resp <= '0;
            end else if (w_xfer) begin
                r_cov <= w_cov_next;
                if (w_mis && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_mis && !r_ff_vld) begin
                    r_ff_vld  <= 1'b1;
                    r_ff_vec  <= in_vec;
                    r_ff_resp <= in_resp;
                end
            end
        end
    end

    // Golden table is deliberately not reset; it is reloaded before each campaign
    always_ff @(posedge CK) begin
        if (gold_we && (r_state != RUN)) begin
            r_gold[gold_addr] <= gold_data;
        end
    end

    trojan_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .en    (w_xfer),
        .clr   (w_start),
        .data  (in_resp),
        .sig   (signature)
    );

    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign in_ready        = busy;
    assign pass            = done && (r_cnt == '0);
    assign mismatch_cnt    = r_cnt;
    assign first_fail_vld  = r_ff_vld;
    assign first_fail_vec  = r_ff_vec;
    assign first_fail_resp = r_ff_resp;

endmodule
`default_nettype wire
